intersection_sched: RTL and testbench

//  Central right-of-way scheduler for the highway/farm-road intersection.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/phase_timer.sv | 20 ++
 rtl/intersection_sched.sv | 85 ++++++++
 tb/tb_intersection_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes and phase encodings shared by the intersection scheduler.
package traffic_pkg;
    localparam int PHASE_W = 3;
    typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} light_t;
    typedef enum logic [PHASE_W-1:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        FW_GREEN  = 3'd3,
        FW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } phase_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: shared down-counter; a load wins over a tick and the count holds at zero.
module phase_timer #(
    parameter int CNT_W   = 16,
    parameter int RST_VAL = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= CNT_W'(RST_VAL);
        else if (load) cnt <= load_val;
        else if (tick_en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = (cnt == '0);
endmodule

// File: rtl/intersection_sched.sv
// intersection_sched: highway/farm-road right-of-way FSM, light decode and invoke pulses.
// PED_WALK_EN adds ped_req/walk and a pedestrian walk phase after ALLRED_B.
module intersection_sched
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int LONG_TICKS   = 1000,
    parameter int SHORT_TICKS  = 100,
    parameter int ALLRED_TICKS = 20,
    parameter int FW_MAX_TICKS = 500,
    parameter int WALK_TICKS   = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_en,
    input  logic         car_on_fw,
`ifdef PED_WALK_EN
    input  logic         ped_req,
    output logic         walk,
`endif
    output logic [1:0]   hw_light,
    output logic [1:0]   fw_light,
    output logic [2:0]   phase,
    output logic         invk_hw,
    output logic         invk_fw
);
    phase_t           state, nxt;
    logic             expired, load, go_walk;
    logic [CNT_W-1:0] load_val;

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(LONG_TICKS)) u_timer (
        .clk(clk), .rst(rst), .tick_en(tick_en), .load(load), .load_val(load_val), .expired(expired)
    );

`ifdef PED_WALK_EN
    logic ped_flag;
    assign go_walk = ped_flag;
    assign walk    = (state == PED_WALK);
    always_ff @(posedge clk) begin
        if (rst) ped_flag <= 1'b0;
        else ped_flag <= (load && nxt == PED_WALK) ? 1'b0 : (ped_flag | ped_req);
    end
`else
    assign go_walk = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            HW_GREEN:  nxt = (expired && car_on_fw) ? HW_YELLOW : HW_GREEN;
            HW_YELLOW: nxt = expired ? ALLRED_A : HW_YELLOW;
            ALLRED_A:  nxt = expired ? FW_GREEN : ALLRED_A;
            FW_GREEN:  nxt = (expired || !car_on_fw) ? FW_YELLOW : FW_GREEN;
            FW_YELLOW: nxt = expired ? ALLRED_B : FW_YELLOW;
            ALLRED_B:  nxt = !expired ? ALLRED_B : go_walk ? PED_WALK : HW_GREEN;
`ifdef PED_WALK_EN
            PED_WALK:  nxt = expired ? HW_GREEN : PED_WALK;
`endif
            default:   nxt = ALLRED_B;
        endcase
    end

    // every transition changes phase, so a phase change is exactly a timer load
    assign load     = (nxt != state);
    assign load_val = (nxt == HW_GREEN) ? CNT_W'(LONG_TICKS) :
                      (nxt == HW_YELLOW || nxt == FW_YELLOW) ? CNT_W'(SHORT_TICKS) :
                      (nxt == ALLRED_A || nxt == ALLRED_B) ? CNT_W'(ALLRED_TICKS) :
                      (nxt == FW_GREEN) ? CNT_W'(FW_MAX_TICKS) : CNT_W'(WALK_TICKS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HW_GREEN;
            invk_hw <= 1'b0;
            invk_fw <= 1'b0;
        end else begin
            state   <= nxt;
            invk_hw <= load && nxt == HW_GREEN;
            invk_fw <= load && nxt == FW_GREEN;
        end
    end

    assign phase    = state;
    assign hw_light = (state == HW_GREEN) ? GREEN : (state == HW_YELLOW) ? YELLOW : RED;
    assign fw_light = (state == FW_GREEN) ? GREEN : (state == FW_YELLOW) ? YELLOW : RED;
endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched: directed scenarios checked against a phase-level model every cycle.
module tb_intersection_sched;
    localparam int LONG = 4, SHORT = 2, ALLRED = 1, FW_MAX = 6, WALK = 3;

    logic clk = 0, rst = 1, tick_en = 1, car_on_fw = 0;
    logic [1:0] hw_light, fw_light;
    logic [2:0] phase;
    logic invk_hw, invk_fw;
`ifdef PED_WALK_EN
    logic ped_req = 0, walk;
`endif
    int checks = 0, errors = 0;

    intersection_sched #(
        .CNT_W(16), .LONG_TICKS(LONG), .SHORT_TICKS(SHORT), .ALLRED_TICKS(ALLRED),
        .FW_MAX_TICKS(FW_MAX), .WALK_TICKS(WALK)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .car_on_fw(car_on_fw),
`ifdef PED_WALK_EN
        .ped_req(ped_req), .walk(walk),
`endif
        .hw_light(hw_light), .fw_light(fw_light), .phase(phase),
        .invk_hw(invk_hw), .invk_fw(invk_fw)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int ph);
        return ph == 0 ? LONG : (ph == 1 || ph == 4) ? SHORT : (ph == 2 || ph == 5) ? ALLRED :
               ph == 3 ? FW_MAX : WALK;
    endfunction

    // model: phase plus ticks left, advanced from the transition table at each edge
    int m_ph = 0, m_left = 0, m_nx = 0;
    bit m_ihw = 0, m_ifw = 0, m_flag = 0, m_valid = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_left = LONG; m_ihw = 0; m_ifw = 0; m_flag = 0; m_valid = 1;
        end else begin
            m_nx = m_ph;
            case (m_ph)
                0: if (m_left == 0 && car_on_fw) m_nx = 1;
                1: if (m_left == 0) m_nx = 2;
                2: if (m_left == 0) m_nx = 3;
                3: if (m_left == 0 || !car_on_fw) m_nx = 4;
                4: if (m_left == 0) m_nx = 5;
                5: if (m_left == 0) m_nx = m_flag ? 6 : 0;
                default: if (m_left == 0) m_nx = 0;
            endcase
            m_ihw = (m_nx == 0 && m_ph != 0);
            m_ifw = (m_nx == 3 && m_ph != 3);
`ifdef PED_WALK_EN
            m_flag = (m_nx == 6 && m_ph != 6) ? 0 : (m_flag | ped_req);
`endif
            if (m_nx != m_ph) m_left = dur(m_nx);
            else if (tick_en && m_left > 0) m_left--;
            m_ph = m_nx;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_phase", phase, m_ph);
            chk("model_hw_light", hw_light, m_ph == 0 ? 1 : m_ph == 1 ? 2 : 0);
            chk("model_fw_light", fw_light, m_ph == 3 ? 1 : m_ph == 4 ? 2 : 0);
            chk("model_invk_hw", invk_hw, m_ihw);
            chk("model_invk_fw", invk_fw, m_ifw);
`ifdef PED_WALK_EN
            chk("model_walk", walk, m_ph == 6);
`endif
            checks++;
            assert (hw_light == 2'd0 || fw_light == 2'd0) else begin
                errors++;
                $display("FAIL light_exclusive: hw=%0d fw=%0d", hw_light, fw_light);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int i = 0;
        while (phase != 3'(ph) && i < budget) begin
            cyc();
            i++;
        end
        chk($sformatf("wait_phase%0d", ph), phase, ph);
    endtask

    task automatic expect_run(input int ph, input int len, input bit hw_pulse);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("run%0d_phase", ph), phase, ph);
            chk($sformatf("run%0d_invk_fw", ph), invk_fw, ph == 3 && i == 0);
            chk($sformatf("run%0d_invk_hw", ph), invk_hw, hw_pulse && i == 0);
            cyc();
        end
    endtask

    initial begin
        int n;
        // 1: no farm car, highway holds green
        car_on_fw = 0;
        do_reset();
        chk("reset_phase", phase, 0);
        chk("reset_hw_light", hw_light, 1);
        chk("reset_fw_light", fw_light, 0);
        chk("reset_invk_hw", invk_hw, 0);
        for (int i = 0; i < 50; i++) begin
            chk("hold_phase", phase, 0);
            chk("hold_hw_light", hw_light, 1);
            chk("hold_fw_light", fw_light, 0);
            cyc();
        end
        // 2: full cycle with car present from reset
        car_on_fw = 1;
        do_reset();
        expect_run(0, 5, 0);
        expect_run(1, 3, 0);
        expect_run(2, 2, 0);
        expect_run(3, 7, 0);
        expect_run(4, 3, 0);
        expect_run(5, 2, 0);
        expect_run(0, 1, 1);
        // 3: early release on FW_GREEN cycle 2
        do_reset();
        wait_phase(3, 20);
        cyc();
        car_on_fw = 0;
        cyc();
        chk("early_phase", phase, 4);
        chk("early_fw_light", fw_light, 2);
        // 4: tick every 4th cycle -> HW_GREEN lasts 14 cycles
        car_on_fw = 1;
        do_reset();
        n = 0;
        while (phase == 3'd0 && n < 100) begin
            tick_en = (n % 4 == 0);
            cyc();
            n++;
        end
        tick_en = 1;
        chk("slow_hw_green_len", n, 14);
        // 5: reset mid FW_GREEN
        do_reset();
        wait_phase(3, 20);
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_phase", phase, 0);
        chk("midrst_hw_light", hw_light, 1);
        chk("midrst_fw_light", fw_light, 0);
        chk("midrst_invk_hw", invk_hw, 0);
        chk("midrst_invk_fw", invk_fw, 0);
`ifdef PED_WALK_EN
        // 6: pedestrian request diverts ALLRED_B into PED_WALK
        do_reset();
        ped_req = 1;
        cyc();
        ped_req = 0;
        wait_phase(5, 30);
        wait_phase(6, 5);
        n = 0;
        while (walk && n < 20) begin
            chk("walk_lights", {hw_light, fw_light}, 0);
            cyc();
            n++;
        end
        chk("walk_len", n, 4);
        chk("post_walk_phase", phase, 0);
        chk("post_walk_invk_hw", invk_hw, 1);
`endif
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
